load_block_stream: RTL and testbench

Parametrised successor to the fixed 25-word block loader. On a start pulse it fetches ceil(size*size/BLOCK) bursts of BLOCK words from the DMA over a req/valid handshake and writes them into an internal DEPTH-word image buffer. It handles a partial final burst, zero size, oversize and DMA stalls, and exposes a synchronous read port. It sits between the DMA and the convolution engine's window fetch.

---
 rtl/load_block_stream.sv | 173 +++++++++++++++++
 tb/tb_load_block_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_block_stream.sv
`default_nettype none
// ============================================================================
// Module      : load_block_stream
// Description : Fetches an image of size*size words from the DMA in bursts of
//               BLOCK words (req/valid handshake) into a DEPTH-word buffer,
//               with a registered read port for the convolution window fetch.
// Revision    : 1.0  initial parametrised release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle load request, sampled in IDLE only
//   size       in   image side length (total words = size*size)
//   base_addr  in   DMA address of the first word
//   dma_req    out  burst request (high while in REQ)
//   dma_addr   out  address of the requested burst
//   dma_valid  in   burst data present
//   dma_data   in   burst data, word i at [i*DATA_W +: DATA_W]
//   rd_addr    in   buffer read address
//   rd_data    out  buffer word (signed), one-cycle latency
//   busy       out  high whenever not IDLE
//   done       out  one-cycle completion pulse
//   err        out  oversize flag, held until next accepted start
// ============================================================================
module load_block_stream #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int SIZE_W = 16,
  parameter int BLOCK  = 25,
  parameter int DEPTH  = 1024,
  localparam int RD_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SIZE_W-1:0]        size,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     dma_req,
  output logic [ADDR_W-1:0]        dma_addr,
  input  logic                     dma_valid,
  input  logic [BLOCK*DATA_W-1:0]  dma_data,
  input  logic [RD_W-1:0]          rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int IDX_W = $clog2(DEPTH + BLOCK);
  localparam int TOT_W = 2 * SIZE_W;
  localparam int IT_W  = 2 * SIZE_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic [IT_W-1:0]   iters_q, iters_d;
  logic [IT_W-1:0]   cnt_q, cnt_d;
  // Buffer index of word 0 of the current burst; tracks cnt*BLOCK by
  // accumulation so no multiplier is needed.
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [TOT_W-1:0]  total_w;
  logic [IT_W-1:0]   iters_w;
  logic              capture_w;

  assign total_w   = {{SIZE_W{1'b0}}, size} * {{SIZE_W{1'b0}}, size};
  // One extra bit so total + BLOCK - 1 cannot overflow.
  assign iters_w   = ({1'b0, total_w} + IT_W'(BLOCK - 1)) / IT_W'(BLOCK);
  assign capture_w = (state_q == S_REQ) && dma_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    total_d = total_q;
    iters_d = iters_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          total_d = total_w;
          iters_d = iters_w;
          cnt_d   = '0;
          widx_d  = '0;
          err_d   = 1'b0;
          if (total_w == '0) begin
            state_d = S_DONE;
          end else if (total_w > TOT_W'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dma_valid) begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q + ADDR_W'(BLOCK);
          widx_d = widx_q + IDX_W'(BLOCK);
          if ((cnt_q + 1'b1) == iters_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      total_q   <= '0;
      iters_q   <= '0;
      cnt_q     <= '0;
      widx_q    <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      total_q   <= total_d;
      iters_q   <= iters_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      err_q     <= err_d;
      // Read before the same-edge capture lands: old data on collision.
      rd_data_q <= mem[rd_addr];
    end
  end

  // Per-word buffer index and keep flag; words at or beyond total are
  // dropped so the tail of a partial final burst leaves the buffer intact.
  logic [IDX_W-1:0] word_idx [BLOCK];
  logic             word_en  [BLOCK];

  for (genvar gi = 0; gi < BLOCK; gi++) begin : g_word
    assign word_idx[gi] = widx_q + IDX_W'(gi);
    assign word_en[gi]  = (TOT_W'(word_idx[gi]) < total_q);
  end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (capture_w) begin
      for (int i = 0; i < BLOCK; i++) begin
        if (word_en[i]) begin
          mem[word_idx[i][RD_W-1:0]] <= dma_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign dma_req  = (state_q == S_REQ);
  assign dma_addr = addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_load_block_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_block_stream
// Description : Self-checking bench for load_block_stream. Random burst data
//               and random loads are compared with an array-based image model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_load_block_stream;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int SIZE_W = 16;
  localparam int BLOCK  = 25;
  localparam int DEPTH  = 1024;
  localparam int RD_W   = 10;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [SIZE_W-1:0]        size;
  logic [ADDR_W-1:0]        base_addr;
  logic                     dma_req;
  logic [ADDR_W-1:0]        dma_addr;
  logic                     dma_valid;
  logic [BLOCK*DATA_W-1:0]  dma_data;
  logic [RD_W-1:0]          rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     busy;
  logic                     done;
  logic                     err;

  load_block_stream #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
    .BLOCK(BLOCK), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .base_addr(base_addr),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_valid(dma_valid),
    .dma_data(dma_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_burst();
    for (int i = 0; i < BLOCK; i++) dma_data[i*DATA_W +: DATA_W] = 16'($urandom);
  endtask

  // mode: 0 plain load, 1 stray start during first burst, 2 reset after 2 bursts
  task automatic do_load(input int sz, input logic [15:0] base,
                         input int stall, input int mode);
    int          total, iters, cyc, wa;
    logic [15:0] addr, old;
    bit          kn, exp_err;
    total = sz * sz;
    iters = (total + BLOCK - 1) / BLOCK;
    start = 1'b1; size = 16'(sz); base_addr = base;
    tick();
    start = 1'b0; size = 16'($urandom); base_addr = 16'($urandom);
    if (total == 0 || total > DEPTH) begin
      exp_err = (total > DEPTH);
      check("short_req",  dma_req, 0);
      check("short_done", done, 1);
      check("short_busy", busy, 1);
      check("short_err",  err, exp_err);
      tick();
      check("short_idle", busy, 0);
      check("short_pulse", done, 0);
      check("err_hold", err, exp_err);
      return;
    end
    check("err_clr", err, 0);
    addr = base;
    cyc  = 0;
    for (int b = 0; b < iters; b++) begin
      for (int s = 0; s < stall; s++) begin
        dma_valid = 1'b0;
        fill_burst();
        check("stall_req", dma_req, 1);
        check("stall_addr", dma_addr, addr);
        tick(); cyc++;
      end
      dma_valid = 1'b1;
      fill_burst();
      check("req", dma_req, 1);
      check("addr", dma_addr, addr);
      check("done_low", done, 0);
      wa = b * BLOCK;
      rd_addr = RD_W'(wa);
      old = ref_mem[wa];
      kn  = ref_known[wa];
      if (mode == 1 && b == 0) begin
        start = 1'b1; size = 16'd3; base_addr = addr + 16'd7;
      end
      tick(); cyc++;
      start = 1'b0;
      if (kn) check("rd_collide_old", {rd_data}, old);
      for (int i = 0; i < BLOCK; i++) begin
        if (wa + i < total) begin
          ref_mem[wa + i]   = dma_data[i*DATA_W +: DATA_W];
          ref_known[wa + i] = 1'b1;
        end
      end
      addr = addr + 16'(BLOCK);
      if (mode == 2 && b == 1) begin
        rst = 1'b1;
        #1;
        check("rst_req", dma_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        dma_valid = 1'b0;
        #1 rst = 1'b0;
        tick();
        check("rst_stay_idle", busy, 0);
        return;
      end
    end
    dma_valid = 1'b0;
    check("done", done, 1);
    check("done_req", dma_req, 0);
    check("done_busy", busy, 1);
    check("latency", cyc, iters * (stall + 1));
    check("done_err", err, 0);
    tick();
    check("idle", busy, 0);
    check("done_pulse", done, 0);
  endtask

  task automatic check_mem(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      if (ref_known[a]) begin
        rd_addr = RD_W'(a);
        tick();
        check($sformatf("rd[%0d]", a), {rd_data}, ref_mem[a]);
      end
    end
  endtask

  initial begin
    int sz;
    rst = 1'b1; start = 1'b0; dma_valid = 1'b0; size = '0; base_addr = '0;
    dma_data = '0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end
    #12;
    check("rst_req", dma_req, 0);
    check("rst_addr", dma_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd", {rd_data}, 0);
    tick();
    rst = 1'b0;
    tick();

    do_load(5, 16'h0100, 0, 0);              // single full burst
    check_mem(0, 24);
    do_load(8, 16'($urandom), 0, 0);         // preload 0..63
    do_load(7, 16'h0000, 0, 0);              // partial second burst
    check_mem(0, 63);
    do_load(0, 16'h1234, 0, 0);              // zero size
    do_load(33, 16'h4321, 0, 0);             // oversize, err set
    check_mem(0, 63);
    do_load(4, 16'($urandom), 0, 0);         // err cleared on next start
    do_load(10, 16'($urandom), 3, 0);        // stalls before every burst
    check_mem(0, 99);
    do_load(9, 16'($urandom), 1, 1);         // ignored start mid-load
    check_mem(0, 80);
    do_load(10, 16'($urandom), 0, 2);        // reset after 2nd burst
    check_mem(0, 99);
    do_load(10, 16'hFFF0, 0, 0);             // address wrap, reload
    check_mem(0, 99);
    for (int r = 0; r < 6; r++) begin
      sz = $urandom_range(0, 34);
      do_load(sz, 16'($urandom), $urandom_range(0, 2), 0);
      check_mem(0, 127);
    end
    do_load(32, 16'($urandom), 0, 0);        // exactly DEPTH words
    check_mem(0, DEPTH - 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
